fetch_queue_rx: RTL and testbench

//  Receiving end of the fetch->decode interface: a small FWFT queue that accepts (pc, inst)

---
 rtl/fetch_queue_rx_pkg.sv | 17 +
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_queue_rx.sv | 115 +++++++++++
 tb/tb_fetch_queue_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_rx_pkg.sv
// Shared definitions for the fetch->decode receive queue: default widths,
// the bubble word driven to ID when nothing is valid, and the per-cycle queue operation.
package fetch_queue_rx_pkg;

    localparam int WIDTH_INST = 32;
    localparam int WIDTH_PC   = 32;

    localparam logic [WIDTH_INST-1:0] INST_BUBBLE = 32'h0;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fq_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Queue storage: DEPTH x W register array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fetch_queue_mem
    import fetch_queue_rx_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = WIDTH_PC + WIDTH_INST,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue_rx.sv
// Fetch->decode receive queue: FWFT buffer of (pc, inst) with valid/ready on both
// sides, flush-on-redirect with a saturating squash counter, zero bubble when empty.
module fetch_queue_rx
    import fetch_queue_rx_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int INST_W = WIDTH_INST,
    parameter int PC_W   = WIDTH_PC,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         squash_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = PC_W + INST_W;
    // Squash sum is computed one bit wider than either operand so saturation is exact.
    localparam int SW = ((CNT_W > LW) ? CNT_W : LW) + 1;
    localparam logic [SW-1:0] SQ_MAX = SW'({CNT_W{1'b1}});

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_squash;

    logic             w_push;
    logic             w_pop;
    fq_op_e           w_op;
    logic [EW-1:0]    w_rdata;
    logic [LW-1:0]    w_sq_inc;
    logic [SW-1:0]    w_sq_sum;
    logic [CNT_W-1:0] w_squash_nxt;

    // in_ready depends on occupancy only, so a full queue never passes through.
    assign in_ready  = (r_level != LW'(DEPTH));
    assign out_valid = (r_level != '0);

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_comb begin
        w_op = OP_IDLE;
        case ({w_pop, w_push})
            2'b01:   w_op = OP_PUSH;
            2'b10:   w_op = OP_POP;
            2'b11:   w_op = OP_BOTH;
            default: w_op = OP_IDLE;
        endcase
    end

    // A flush drops everything held plus the entry IF offers that cycle, if it would have fit.
    assign w_sq_inc     = r_level + LW'(in_valid & in_ready);
    assign w_sq_sum     = SW'(r_squash) + SW'(w_sq_inc);
    assign w_squash_nxt = (w_sq_sum > SQ_MAX) ? {CNT_W{1'b1}} : w_sq_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_squash <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_squash <= w_squash_nxt;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_level  <= r_level + LW'(1);
                end
                OP_POP: begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_level  <= r_level - LW'(1);
                end
                OP_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push & ~rst),
        .waddr (r_wr_ptr),
        .wdata ({in_pc, in_inst}),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign out_pc     = out_valid ? w_rdata[INST_W +: PC_W] : '0;
    assign out_inst   = out_valid ? w_rdata[INST_W-1:0] : INST_W'(INST_BUBBLE);
    assign level      = r_level;
    assign squash_cnt = r_squash;

endmodule

// File: tb/tb_fetch_queue_rx.sv
// Scoreboard bench for fetch_queue_rx: directed scenarios then random traffic, checked
// against a queue-based reference; a second instance with a 2-bit squash counter checks saturation.
module tb_fetch_queue_rx;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [31:0] out_pc,    out_pc_s;
    logic [31:0] out_inst,  out_inst_s;
    logic [1:0]  level,     level_s;
    logic [15:0] squash_cnt;
    logic [1:0]  squash_cnt_s;

    always #5 clk = ~clk;

    fetch_queue_rx #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_ready(out_ready), .level(level), .squash_cnt(squash_cnt)
    );

    fetch_queue_rx #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready_s), .flush(flush), .out_valid(out_valid_s), .out_pc(out_pc_s),
        .out_inst(out_inst_s), .out_ready(out_ready), .level(level_s), .squash_cnt(squash_cnt_s)
    );

    int errors = 0;
    int checks = 0;

    // Reference: entries in order as {pc, inst}; total squashed entries, unbounded.
    logic [63:0] exp_q[$];
    int unsigned sq_total = 0;
    bit          popped   = 0;
    bit          mon_on   = 0;
    bit          acc      = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] sat(int unsigned v, int unsigned mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    // Monitor: compare everything the DUT presents, pop the head when ID takes it.
    initial begin
        bit v;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                v = (exp_q.size() != 0);
                chk("in_ready",   in_ready,  64'(exp_q.size() < DEPTH));
                chk("out_valid",  out_valid, 64'(v));
                chk("level",      level,     64'(exp_q.size()));
                chk("out_pc",     out_pc,    v ? 64'(exp_q[0][63:32]) : 64'd0);
                chk("out_inst",   out_inst,  v ? 64'(exp_q[0][31:0])  : 64'd0);
                chk("squash_cnt", squash_cnt,   sat(sq_total, 65535));
                chk("squash_sat", squash_cnt_s, sat(sq_total, 3));
                chk("sat_out_pc", out_pc_s,  v ? 64'(exp_q[0][63:32]) : 64'd0);
                if (v && out_ready && !flush && !rst) begin
                    void'(exp_q.pop_front());
                    popped = 1;
                end
            end
        end
    end

    // One clock of stimulus; the reference is advanced from the pre-edge occupancy.
    task automatic step(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit ordy, input bit fl);
        int occ;
        rst = r; in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
        @(posedge clk);
        occ    = exp_q.size() + (popped ? 1 : 0);
        popped = 0;
        acc    = 0;
        if (r) begin
            exp_q.delete();
            sq_total = 0;
        end else if (fl) begin
            sq_total += occ + ((v && occ < DEPTH) ? 1 : 0);
            exp_q.delete();
        end else if (v && occ < DEPTH) begin
            exp_q.push_back({pc, inst});
            acc = 1;
        end
        mon_on = 1;
        #1;
    endtask

    function automatic logic [31:0] iw(logic [31:0] pc);
        return pc ^ 32'hA5C3_0013;
    endfunction

    initial begin
        bit          rv, rfl, rord, hold;
        logic [31:0] rpc, rinst;

        // T1 reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_out_valid", out_valid, 0);
        chk("t1_level", level, 0);
        chk("t1_out_inst", out_inst, 0);

        // T2 streaming
        step(0, 1, 32'h00, iw(32'h00), 1, 0);
        chk("t2_first_pc", out_pc, 32'h00);
        step(0, 1, 32'h04, iw(32'h04), 1, 0);
        step(0, 1, 32'h08, iw(32'h08), 1, 0);
        chk("t2_level", level, 1);
        step(0, 0, 0, 0, 1, 0);

        // T3 stall / full / held request
        step(0, 1, 32'h10, iw(32'h10), 0, 0);
        step(0, 1, 32'h14, iw(32'h14), 0, 0);
        step(0, 1, 32'h18, iw(32'h18), 0, 0);
        chk("t3_full_level", level, 2);
        chk("t3_full_ready", in_ready, 0);
        step(0, 1, 32'h18, iw(32'h18), 1, 0);
        step(0, 1, 32'h18, iw(32'h18), 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // T4 flush with a full queue: IF's offer is not counted since in_ready is low
        step(0, 1, 32'h20, iw(32'h20), 0, 0);
        step(0, 1, 32'h24, iw(32'h24), 0, 0);
        step(0, 1, 32'h28, iw(32'h28), 0, 1);
        chk("t4_level", level, 0);
        chk("t4_bubble", out_inst, 0);
        chk("t4_squash", squash_cnt, 2);
        step(0, 1, 32'h40, iw(32'h40), 0, 0);
        chk("t4_refetch", out_pc, 32'h40);
        // flush at level 1 with an accepted-able offer counts both
        step(0, 1, 32'h44, iw(32'h44), 0, 1);
        chk("t4_squash2", squash_cnt, 4);

        // T6 saturation and mid-stream reset
        step(0, 1, 32'h50, iw(32'h50), 0, 0);
        step(0, 1, 32'h54, iw(32'h54), 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_sat", squash_cnt_s, 3);
        chk("t6_wide", squash_cnt, 6);
        step(0, 1, 32'h60, iw(32'h60), 0, 0);
        step(1, 1, 32'h64, iw(32'h64), 1, 0);
        chk("t6_rst_cnt", squash_cnt, 0);
        chk("t6_rst_level", level, 0);

        // T5 random traffic: wrap, stalls, occasional flush; IF holds an unaccepted request
        hold = 0; rv = 0; rpc = 0; rinst = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rv    = ($urandom_range(3) != 0);
                rpc   = $urandom & 32'hFFFF_FFFC;
                rinst = $urandom;
            end
            rord = ($urandom_range(1) == 1);
            rfl  = ($urandom_range(19) == 0);
            step(0, rv, rpc, rinst, rord, rfl);
            hold = rv && !acc && !rfl;
        end

        // drain
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        chk("drain_empty", out_valid, 0);

        mon_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
